hicore_irq_cond: RTL and testbench
==================================

Name: hicore_irq_cond

Overview:
- External interrupt conditioner directly upstream of the PLIC top.
- Takes raw asynchronous interrupt lines (uart_irq, ext_irq0, ext_irq1) and passes each through:
  - a 2-flop synchroniser,
  - a programmable glitch filter,
  - a polarity select,
  - a level or rising-edge capture with a software-clearable pending bit.
- Outputs clean synchronous levels that feed the PLIC irq inputs.
- Configured through a small ICB slave on the peripheral bus.

Parameters:
- IRQ_NUM, 3, number of conditioned sources (1..8).
- FILT_W, 4, width of the per-source glitch-filter counter and of the FILT register field.
- ADDR_W, 32, ICB address width.
- DATA_W, 32, ICB data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_read  in  1  1 = read, 0 = write
- icb_cmd_addr  in  ADDR_W  byte address; only addr[4:2] decoded
- icb_cmd_wdata  in  DATA_W  write data
- icb_cmd_wmask  in  DATA_W/8  byte enables; only lane 0 is used
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_rdata  out  DATA_W  read data
- icb_rsp_err  out  1  access to an unmapped offset
- irq_in  in  IRQ_NUM  raw asynchronous interrupt lines
- irq_out  out  IRQ_NUM  conditioned interrupts to the PLIC

Behaviour:
- Register map (word offsets; bits [IRQ_NUM-1:0] unless noted):
  - 0x00 MODE: 0 = level, 1 = rising edge. Reset 0.
  - 0x04 POL: 1 = invert input. Reset 0.
  - 0x08 FILT: bits [FILT_W-1:0], shared filter threshold. Reset 0.
  - 0x0C PEND: read pending bits; write 1 clears. Reset 0.
  - 0x10 RAW: read-only filtered value, pre-polarity.
  - Offsets 0x14–0x1C: read 0, write ignored, rsp_err = 1.
- Writes take effect only when wmask[0] = 1.
- ICB handshake:
  - One outstanding transaction.
  - icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready.
  - An accepted command produces icb_rsp_valid on the next cycle, held with stable rdata/err until icb_rsp_ready.
  - Register write lands on the accept edge.
  - Reset values: icb_rsp_valid 0, icb_rsp_rdata 0, icb_rsp_err 0.
- Synchroniser: s1 <= irq_in, s2 <= s1. Reset 0.
- Filter, per source, counter cnt and filtered bit f (reset 0):
  - s2 == f: cnt <= 0.
  - s2 != f and cnt == FILT: f <= s2, cnt <= 0.
  - Otherwise cnt <= cnt + 1.
  - A change must persist FILT+1 consecutive cycles. cnt never exceeds FILT.
  - Lowering FILT below the current cnt causes immediate acceptance on the next differing cycle.
- Polarized value p = f ^ POL.
- Level mode: lvl_q <= p, irq_out = lvl_q. PEND bit stays 0 (forced clear).
- Edge mode:
  - p_d <= p.
  - Rise = p & ~p_d sets PEND on the next edge.
  - irq_out = PEND.
  - The same-cycle rise and write-1-clear: set wins.
  - Writing 1 to a clear bit has no effect; writing 0 has no effect.
- Latency, FILT = 0, input rising before edge 1:
  - Level mode: irq_out high after edge 4.
  - Edge mode: PEND and irq_out high after edge 4.
  - Each extra FILT count adds 1 cycle.
- Changing POL or MODE at runtime:
  - A resulting p rise in edge mode sets PEND (software clears it).
  - Switching edge→level clears PEND next cycle.
- Reset mid-operation: all flops (sync, filter, PEND, registers, ICB response) return to reset values asynchronously; irq_out = 0 immediately.
- Pulses shorter than one clock may be lost (accepted).

Optional Feature:
- Macro: HICORE_IRQ_COND_FILT_EN.
- Defined: glitch filter as above.
- Undefined:
  - Filter removed: f = s2 directly.
  - FILT reads 0; writes are ignored without error.
  - Latency from input change to irq_out drops to 3 edges.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C: rdata 0, err 0, each response one cycle after accept. Read 0x18: rdata 0, err 1.
- Level mode, FILT = 0: irq_in[1] 0→1 before edge 1 → irq_out[1] = 1 after edge 4. Input low → irq_out[1] = 0 four edges later.
- FILT = 3:
  - A 3-cycle high glitch on irq_in[0] → irq_out[0] stays 0, RAW bit 0 stays 0.
  - A 4-cycle high on irq_in[0] → irq_out[0] rises.
  - Without the macro: both pulses pass.
- MODE = 0b001: irq_in[0] rises and stays high → PEND = 0b001 and irq_out[0] = 1. Write 0x0C = 0b001 → PEND 0 next cycle, no re-set while held high.
- Edge mode: inject a new rise on the same cycle as a write-1-clear → PEND remains 1.
- POL = 0b100 with irq_in[2] = 0:
  - Level mode → irq_out[2] = 1.
  - Hold icb_rsp_ready = 0 during a read → cmd_ready = 0, rsp held stable.
  - Assert rst_n low mid-transaction → all outputs 0 asynchronously.

Source files
------------

// File: rtl/hicore_irq_cond.sv
// hicore_irq_cond -- external interrupt conditioner in front of the PLIC.
//
// Each raw asynchronous line passes through a 2-flop synchroniser, an
// optional glitch filter, a polarity select and a level / rising-edge
// capture stage. A small ICB slave holds the configuration.
//
// Build option: define HICORE_IRQ_COND_FILT_EN to include the glitch filter.
// Without it the filter is bypassed, and the FILT register reads 0 and
// ignores writes.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   icb_cmd_*            ICB command channel (addr[4:2] decoded, wmask[0] used)
//   icb_rsp_*            ICB response channel (one outstanding transaction)
//   irq_in               raw asynchronous interrupt lines
//   irq_out              conditioned interrupt levels to the PLIC
//
// Register map (word offsets):
//   0x00 MODE  0 = level, 1 = rising edge
//   0x04 POL   1 = invert input
//   0x08 FILT  shared filter threshold, bits [FILT_W-1:0]
//   0x0C PEND  pending bits, write 1 to clear
//   0x10 RAW   filtered value before polarity (read-only)
//   0x14-0x1C  unmapped: read 0, writes ignored, rsp_err = 1
module hicore_irq_cond #(
  parameter int IRQ_NUM = 3,
  parameter int FILT_W  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic                  icb_cmd_read,
  input  logic [ADDR_W-1:0]     icb_cmd_addr,
  input  logic [DATA_W-1:0]     icb_cmd_wdata,
  input  logic [DATA_W/8-1:0]   icb_cmd_wmask,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic [DATA_W-1:0]     icb_rsp_rdata,
  output logic                  icb_rsp_err,
  input  logic [IRQ_NUM-1:0]    irq_in,
  output logic [IRQ_NUM-1:0]    irq_out
);

  // ICB decode
  logic              cmd_accept;
  logic              wr_en;
  logic [2:0]        off;
  logic [DATA_W-1:0] rd_data;
  logic              addr_err;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // Configuration and condition state
  logic [IRQ_NUM-1:0] mode_q, mode_d;
  logic [IRQ_NUM-1:0] pol_q, pol_d;
  logic [IRQ_NUM-1:0] pend_q, pend_d;
  logic [IRQ_NUM-1:0] lvl_q;
  logic [IRQ_NUM-1:0] pd_q;
  logic [IRQ_NUM-1:0] s1_q, s2_q;
  logic [IRQ_NUM-1:0] filt_val;
  logic [IRQ_NUM-1:0] pol_val;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] clr;

  // Address and data bits outside the decoded fields are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};

  assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
  assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;
  assign wr_en         = cmd_accept & ~icb_cmd_read & icb_cmd_wmask[0];
  assign off           = icb_cmd_addr[4:2];

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;

  // Synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
    end
  end

`ifdef HICORE_IRQ_COND_FILT_EN
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic [FILT_W-1:0]  cnt_q [IRQ_NUM];
  logic [FILT_W-1:0]  cnt_d [IRQ_NUM];
  logic [IRQ_NUM-1:0] f_q, f_d;

  // A change is accepted once it has been seen FILT+1 consecutive cycles.
  // The >= compare lets a lowered threshold take effect at once.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < IRQ_NUM; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] >= filt_q) begin
          f_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    filt_d = filt_q;
    if (wr_en && off == 3'd2) begin
      filt_d = icb_cmd_wdata[FILT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      filt_q <= '0;
      for (int i = 0; i < IRQ_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      f_q    <= f_d;
      filt_q <= filt_d;
      for (int i = 0; i < IRQ_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign filt_val = f_q;
`else
  assign filt_val = s2_q;
`endif

  assign pol_val = filt_val ^ pol_q;
  assign rise    = pol_val & ~pd_q;
  assign clr     = (wr_en && off == 3'd3) ? icb_cmd_wdata[IRQ_NUM-1:0] : '0;

  // A new rise beats a simultaneous write-1-clear; level-mode bits stay clear.
  always_comb begin
    mode_d = mode_q;
    pol_d  = pol_q;
    pend_d = mode_q & ((pend_q & ~clr) | rise);
    if (wr_en && off == 3'd0) mode_d = icb_cmd_wdata[IRQ_NUM-1:0];
    if (wr_en && off == 3'd1) pol_d  = icb_cmd_wdata[IRQ_NUM-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      lvl_q  <= '0;
      pd_q   <= '0;
    end else begin
      mode_q <= mode_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      lvl_q  <= pol_val;
      pd_q   <= pol_val;
    end
  end

  assign irq_out = (mode_q & pend_q) | (~mode_q & lvl_q);

  // Read mux
  always_comb begin
    rd_data  = '0;
    addr_err = 1'b0;
    case (off)
      3'd0: rd_data[IRQ_NUM-1:0] = mode_q;
      3'd1: rd_data[IRQ_NUM-1:0] = pol_q;
      3'd2: begin
`ifdef HICORE_IRQ_COND_FILT_EN
        rd_data[FILT_W-1:0] = filt_q;
`endif
      end
      3'd3: rd_data[IRQ_NUM-1:0] = pend_q;
      3'd4: rd_data[IRQ_NUM-1:0] = filt_val;
      default: addr_err = 1'b1;
    endcase
  end

  // Response holds until the requester takes it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (cmd_accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = icb_cmd_read ? rd_data : '0;
      rsp_err_d   = addr_err;
    end else if (icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_hicore_irq_cond.sv
module tb_hicore_irq_cond;

`ifdef HICORE_IRQ_COND_FILT_EN
  localparam int LAT = 4;
  localparam bit FEN = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit FEN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  irq_in;
  logic [2:0]  irq_out;

  int n_chk;
  int n_fail;

  hicore_irq_cond dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icb_cmd_valid(cmd_valid),
    .icb_cmd_ready(cmd_ready),
    .icb_cmd_read (cmd_read),
    .icb_cmd_addr (cmd_addr),
    .icb_cmd_wdata(cmd_wdata),
    .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rsp_valid),
    .icb_rsp_ready(rsp_ready),
    .icb_rsp_rdata(rsp_rdata),
    .icb_rsp_err  (rsp_err),
    .irq_in       (irq_in),
    .irq_out      (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic icb_do(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdat, output logic err, output logic vld);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wmask = 4'h1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    vld  = rsp_valid;
    rdat = rsp_rdata;
    err  = rsp_err;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] d;
    logic e, v;
    icb_do(1'b0, addr, wd, d, e, v);
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic e, v;
    icb_do(1'b1, addr, 32'h0, d, e, v);
    check({tag, "_vld"}, 32'(v), 32'd1);
    check({tag, "_err"}, 32'(e), 32'd0);
    check(tag, d, exp);
  endtask

  task automatic pulse0(input int width, output logic seen);
    @(negedge clk);
    irq_in[0] = 1'b1;
    seen = 1'b0;
    repeat (width) begin
      @(posedge clk);
      #1;
      seen |= irq_out[0];
    end
    @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen |= irq_out[0];
    end
  endtask

  initial begin
    logic [31:0] d;
    logic e, v, seen;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_read = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b1;
    irq_in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq_out", 32'(irq_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values of the map and an unmapped offset
    reg_rd("rd_mode", 32'h00, 32'h0);
    reg_rd("rd_pol", 32'h04, 32'h0);
    reg_rd("rd_filt", 32'h08, 32'h0);
    reg_rd("rd_pend", 32'h0C, 32'h0);
    icb_do(1'b1, 32'h18, 32'h0, d, e, v);
    check("unmapped_vld", 32'(v), 32'd1);
    check("unmapped_err", 32'(e), 32'd1);
    check("unmapped_rdata", d, 32'h0);

    // Level mode, threshold 0
    @(negedge clk);
    irq_in[1] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 check("lvl_rise_early", 32'(irq_out[1]), 32'd0);
    @(posedge clk);
    #1 check("lvl_rise", 32'(irq_out[1]), 32'd1);
    reg_rd("lvl_raw", 32'h10, 32'h2);
    reg_rd("lvl_pend_zero", 32'h0C, 32'h0);
    @(negedge clk);
    irq_in[1] = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 check("lvl_fall_early", 32'(irq_out[1]), 32'd1);
    @(posedge clk);
    #1 check("lvl_fall", 32'(irq_out[1]), 32'd0);

    // Glitch filter, threshold 3
    reg_wr(32'h08, 32'h3);
    reg_rd("filt_rb", 32'h08, FEN ? 32'h3 : 32'h0);
    pulse0(3, seen);
    check("glitch3_out", 32'(seen), FEN ? 32'd0 : 32'd1);
    reg_rd("glitch3_raw", 32'h10, 32'h0);
    pulse0(4, seen);
    check("pulse4_out", 32'(seen), 32'd1);
    check("pulse4_settled", 32'(irq_out[0]), 32'd0);
    reg_wr(32'h08, 32'h0);

    // Edge mode on source 0
    reg_wr(32'h00, 32'h1);
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 check("edge_early", 32'(irq_out[0]), 32'd0);
    @(posedge clk);
    #1 check("edge_set", 32'(irq_out[0]), 32'd1);
    reg_rd("edge_pend", 32'h0C, 32'h1);
    reg_wr(32'h0C, 32'h1);
    check("edge_clr_out", 32'(irq_out[0]), 32'd0);
    repeat (5) @(posedge clk);
    #1 check("edge_no_reset_held", 32'(irq_out[0]), 32'd0);
    reg_rd("edge_pend_clr", 32'h0C, 32'h0);

    // Pending latches through the input going low
    @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("edge_latched", 32'(irq_out[0]), 32'd1);

    // New rise lands on the same edge as a write-1-clear
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    reg_wr(32'h0C, 32'h1);
    reg_rd("set_beats_clr", 32'h0C, 32'h1);
    reg_wr(32'h0C, 32'h0);
    reg_rd("wr0_no_effect", 32'h0C, 32'h1);
    reg_wr(32'h0C, 32'h1);
    reg_rd("pend_cleared", 32'h0C, 32'h0);
    @(negedge clk);
    irq_in[0] = 1'b0;
    reg_wr(32'h00, 32'h0);
    repeat (6) @(posedge clk);

    // Polarity inversion in level mode
    reg_wr(32'h04, 32'h4);
    repeat (2) @(posedge clk);
    #1 check("pol_inv", 32'(irq_out), 32'h4);

    // Response back-pressure
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_addr  = 32'h04;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_addr = 32'h00;
    check("stall_vld", 32'(rsp_valid), 32'd1);
    check("stall_rdata", rsp_rdata, 32'h4);
    check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("stall_hold_vld", 32'(rsp_valid), 32'd1);
    check("stall_hold_rdata", rsp_rdata, 32'h4);
    check("stall_hold_err", 32'(rsp_err), 32'd0);

    // Asynchronous reset in the middle of the stalled transaction
    #2 rst_n = 1'b0;
    #1;
    check("arst_irq_out", 32'(irq_out), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_rdata", rsp_rdata, 32'h0);
    check("arst_rsp_err", 32'(rsp_err), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd("post_rst_pol", 32'h04, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("post_rst_out", 32'(irq_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
